// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction fetch stage for the mriscv core.
// Reads one word per instruction from a valid/ready memory read port at the PC supplied by
// the PC/CSR utility stage, holds it for decode and takes inst_ack as the PC-advance strobe.
// Handles flush (redirect/interrupt), misaligned PCs, bus errors and response timeouts.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-low reset
//   pc_in               current PC from the utility stage
//   flush               discard in-flight/held fetch and refetch from pc_in
//   mem_arvalid/araddr  read address request (word aligned), accepted by mem_arready
//   mem_rvalid/rdata    read response, mem_rerr flags a bus error, accepted by mem_rready
//   inst_valid          inst/inst_pc/fault valid to decode, stable until inst_ack
//   fault               00 none, 01 misaligned, 10 bus error, 11 timeout
//   inst_ack            decode consumes the instruction
module inst_fetch_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic        flush,
    output logic        mem_arvalid,
    output logic [31:0] mem_araddr,
    input  logic        mem_arready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rerr,
    output logic        mem_rready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [1:0]  fault,
    input  logic        inst_ack
);

    localparam logic [31:0] Nop      = 32'h00000013;
    localparam logic [15:0] TimerMax = 16'(TIMEOUT);

    localparam logic [1:0] FaultNone     = 2'b00;
    localparam logic [1:0] FaultMisalign = 2'b01;
    localparam logic [1:0] FaultBus      = 2'b10;
    localparam logic [1:0] FaultTimeout  = 2'b11;

    typedef enum logic [2:0] {StIdle, StAddr, StData, StHold, StDrain} state_e;

    state_e      state_q;
    logic [31:0] fetch_pc_q;
    logic        addr_first_q;
    logic [15:0] timer_q;

    logic [31:0] addr_pc;
    logic        addr_ok;
    logic        ar_hs;
    logic        timer_done;

    // The utility stage advances the PC on the same edge that moves us into ADDR, so the
    // first ADDR cycle must use pc_in directly; later ADDR cycles use the latched copy,
    // which keeps araddr stable while waiting for mem_arready.
    assign addr_pc     = (state_q == StAddr && addr_first_q) ? pc_in : fetch_pc_q;
    assign addr_ok     = (addr_pc[1:0] == 2'b00);
    assign mem_arvalid = (state_q == StAddr) && addr_ok;
    assign mem_araddr  = {addr_pc[31:2], 2'b00};
    assign ar_hs       = mem_arvalid && mem_arready;
    // True on the TIMEOUT-th cycle spent waiting in DATA/DRAIN.
    assign timer_done  = (timer_q == TimerMax - 16'd1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            fetch_pc_q   <= 32'd0;
            addr_first_q <= 1'b0;
            timer_q      <= 16'd0;
            mem_rready   <= 1'b0;
            inst_valid   <= 1'b0;
            inst         <= Nop;
            inst_pc      <= 32'd0;
            fault        <= FaultNone;
        end else begin
            unique case (state_q)
                StIdle: begin
                    fetch_pc_q   <= pc_in;
                    addr_first_q <= 1'b1;
                    state_q      <= StAddr;
                end

                StAddr: begin
                    fetch_pc_q   <= addr_pc;
                    addr_first_q <= 1'b0;
                    if (flush) begin
                        if (ar_hs) begin
                            // Request already accepted: its response must be drained.
                            mem_rready <= 1'b1;
                            timer_q    <= 16'd0;
                            state_q    <= StDrain;
                        end else begin
                            addr_first_q <= 1'b1;
                        end
                    end else if (!addr_ok) begin
                        inst_valid <= 1'b1;
                        inst       <= Nop;
                        inst_pc    <= addr_pc;
                        fault      <= FaultMisalign;
                        state_q    <= StHold;
                    end else if (ar_hs) begin
                        mem_rready <= 1'b1;
                        timer_q    <= 16'd0;
                        state_q    <= StData;
                    end
                end

                StData: begin
                    if (mem_rvalid) begin
                        mem_rready <= 1'b0;
                        if (flush) begin
                            addr_first_q <= 1'b1;
                            state_q      <= StAddr;
                        end else begin
                            inst_valid <= 1'b1;
                            inst       <= mem_rerr ? Nop : mem_rdata;
                            inst_pc    <= fetch_pc_q;
                            fault      <= mem_rerr ? FaultBus : FaultNone;
                            state_q    <= StHold;
                        end
                    end else if (flush) begin
                        timer_q <= 16'd0;
                        state_q <= StDrain;
                    end else if (timer_done) begin
                        mem_rready <= 1'b0;
                        timer_q    <= TimerMax;
                        inst_valid <= 1'b1;
                        inst       <= Nop;
                        inst_pc    <= fetch_pc_q;
                        fault      <= FaultTimeout;
                        state_q    <= StHold;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end

                StHold: begin
                    // flush and inst_ack both restart the fetch from pc_in.
                    if (flush || inst_ack) begin
                        inst_valid   <= 1'b0;
                        addr_first_q <= 1'b1;
                        state_q      <= StAddr;
                    end
                end

                StDrain: begin
                    if (mem_rvalid || timer_done) begin
                        mem_rready   <= 1'b0;
                        addr_first_q <= 1'b1;
                        state_q      <= StAddr;
                    end
                    if (timer_done) begin
                        timer_q <= TimerMax;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
